// File: rtl/attribute_residual_encoder.sv
// Delta-residual encoder: clamps (attr - prediction) to the symbol range and queues
// signed symbols in a small FIFO; the prediction follows the decoder's reconstruction.
module attribute_residual_encoder #(
    parameter int ATTR_WIDTH   = 8,
    parameter int SYMBOL_WIDTH = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ATTR_WIDTH-1:0]   in_attr,
    input  logic                    in_first,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYMBOL_WIDTH-1:0] out_symbol,
    output logic                    out_first,
    input  logic                    stats_clear,
    output logic [CNT_WIDTH-1:0]    sym_count,
    output logic [CNT_WIDTH-1:0]    sat_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]     FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]     COUNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; in_ready comes only from the registered count, out_valid means FIFO non-empty.

    logic [SYMBOL_WIDTH:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [PTR_W:0]          r_count;
    logic [ATTR_WIDTH-1:0]   r_pred;
    logic [CNT_WIDTH-1:0]    r_sym_count;
    logic [CNT_WIDTH-1:0]    r_sat_count;

    logic                    w_push;
    logic                    w_pop;
    logic [ATTR_WIDTH-1:0]   w_p;
    logic signed [ATTR_WIDTH:0] w_resid;
    logic signed [ATTR_WIDTH:0] w_rc;
    logic signed [ATTR_WIDTH:0] w_sym_max;
    logic signed [ATTR_WIDTH:0] w_sym_min;
    logic                    w_sat;
    logic [ATTR_WIDTH:0]     w_sum;
    logic [ATTR_WIDTH-1:0]   w_pred_next;
    logic [SYMBOL_WIDTH-1:0] w_symbol;

    assign in_ready  = (r_count != FULL_CNT);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_symbol = r_mem[r_rd_ptr][SYMBOL_WIDTH:1];
    assign out_first  = r_mem[r_rd_ptr][0];
    assign sym_count  = r_sym_count;
    assign sat_count  = r_sat_count;

    // Symbol range bounds expressed in the (ATTR_WIDTH+1)-bit residual domain.
    assign w_sym_max = $signed({{(ATTR_WIDTH + 2 - SYMBOL_WIDTH){1'b0}}, {(SYMBOL_WIDTH - 1){1'b1}}});
    assign w_sym_min = $signed({{(ATTR_WIDTH + 2 - SYMBOL_WIDTH){1'b1}}, {(SYMBOL_WIDTH - 1){1'b0}}});

    always_comb begin
        w_p         = '0;
        w_resid     = '0;
        w_rc        = '0;
        w_sat       = 1'b0;
        w_sum       = '0;
        w_pred_next = '0;
        w_symbol    = '0;

        w_p     = in_first ? '0 : r_pred;
        w_resid = $signed({1'b0, in_attr}) - $signed({1'b0, w_p});
        if (w_resid > w_sym_max) begin
            w_rc  = w_sym_max;
            w_sat = 1'b1;
        end else if (w_resid < w_sym_min) begin
            w_rc  = w_sym_min;
            w_sat = 1'b1;
        end else begin
            w_rc = w_resid;
        end
        w_symbol    = w_rc[SYMBOL_WIDTH-1:0];
        // Reconstruction the decoder will see; clamping moves toward in_attr so it stays in range.
        w_sum       = {1'b0, w_p} + $unsigned(w_rc);
        w_pred_next = w_sum[ATTR_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_pred   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_symbol, in_first};
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
                r_pred          <= w_pred_next;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + COUNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_count <= '0;
            r_sat_count <= '0;
        end else if (stats_clear) begin
            r_sym_count <= '0;
            r_sat_count <= '0;
        end else if (w_push) begin
            r_sym_count <= r_sym_count + STAT_ONE;
            if (w_sat && !(&r_sat_count)) begin
                r_sat_count <= r_sat_count + STAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_attribute_residual_encoder.sv
// Bench for attribute_residual_encoder: directed and random attribute streams scored
// against an arithmetic reference model; a narrow-counter instance checks saturation.
module tb_attribute_residual_encoder;

    localparam int AW = 8;
    localparam int SW = 8;
    localparam int DEPTH = 4;
    localparam int CW = 16;
    localparam int CW4 = 4;
    localparam int SYM_MAX = (1 << (SW - 1)) - 1;
    localparam int SYM_MIN = -(1 << (SW - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] in_attr = '0;
    logic          in_first = 1'b0;
    logic          out_ready = 1'b1;
    logic          stats_clear = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [SW-1:0] out_symbol;
    logic          out_first;
    logic [CW-1:0] sym_count;
    logic [CW-1:0] sat_count;
    logic          in_ready4;
    logic          out_valid4;
    logic [SW-1:0] out_symbol4;
    logic          out_first4;
    logic [CW4-1:0] sym_count4;
    logic [CW4-1:0] sat_count4;

    int n_tests = 0;
    int n_fail = 0;
    logic rand_rdy = 1'b0;

    logic [SW:0] exp_q[$];
    int m_pred = 0;
    int m_cnt = 0;
    int m_sym = 0;
    int m_sat = 0;
    int m_sym4 = 0;
    int m_sat4 = 0;

    attribute_residual_encoder #(
        .ATTR_WIDTH(AW), .SYMBOL_WIDTH(SW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_attr(in_attr), .in_first(in_first), .out_valid(out_valid),
        .out_ready(out_ready), .out_symbol(out_symbol), .out_first(out_first),
        .stats_clear(stats_clear), .sym_count(sym_count), .sat_count(sat_count)
    );

    attribute_residual_encoder #(
        .ATTR_WIDTH(AW), .SYMBOL_WIDTH(SW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW4)
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_attr(in_attr), .in_first(in_first), .out_valid(out_valid4),
        .out_ready(out_ready), .out_symbol(out_symbol4), .out_first(out_first4),
        .stats_clear(stats_clear), .sym_count(sym_count4), .sat_count(sat_count4)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO occupancy, prediction and counters, updated once per cycle
    // for the edge that follows this falling edge.
    always @(negedge clk) begin
        int p;
        int r;
        int rc;
        logic acc;
        logic pop;
        logic [SW-1:0] sym;
        if (!rst_n) begin
            m_pred = 0;
            m_cnt = 0;
            m_sym = 0;
            m_sat = 0;
            m_sym4 = 0;
            m_sat4 = 0;
            exp_q.delete();
        end else begin
            chk("in_ready", 32'(in_ready), 32'(m_cnt != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
            chk("sym_count", 32'(sym_count), 32'(m_sym));
            chk("sat_count", 32'(sat_count), 32'(m_sat));
            chk("sym_count4", 32'(sym_count4), 32'(m_sym4));
            chk("sat_count4", 32'(sat_count4), 32'(m_sat4));
            acc = in_valid && (m_cnt != DEPTH);
            pop = (m_cnt != 0) && out_ready;
            if (acc) begin
                p = in_first ? 0 : m_pred;
                r = int'(in_attr) - p;
                rc = (r > SYM_MAX) ? SYM_MAX : ((r < SYM_MIN) ? SYM_MIN : r);
                sym = SW'(rc);
                exp_q.push_back({sym, in_first});
                m_pred = p + rc;
                if (stats_clear) begin
                    m_sym = 0; m_sat = 0; m_sym4 = 0; m_sat4 = 0;
                end else begin
                    m_sym = (m_sym + 1) % (1 << CW);
                    m_sym4 = (m_sym4 + 1) % (1 << CW4);
                    if (rc != r) begin
                        if (m_sat < (1 << CW) - 1) m_sat++;
                        if (m_sat4 < (1 << CW4) - 1) m_sat4++;
                    end
                end
            end else if (stats_clear) begin
                m_sym = 0; m_sat = 0; m_sym4 = 0; m_sat4 = 0;
            end
            m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // Monitor: compare every popped symbol against the scoreboard head
    always @(negedge clk) begin
        logic [SW:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_symbol", 32'({out_symbol, out_first}), 32'h1ff);
            end else begin
                e = exp_q.pop_front();
                chk("out_symbol", 32'(out_symbol), 32'(e[SW:1]));
                chk("out_first", 32'(out_first), 32'(e[0]));
            end
        end
    end

    // Driver: hold one attribute until it is accepted (bounded)
    task automatic send(input logic [AW-1:0] a, input logic f, input logic clr);
        logic acc;
        int n;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_attr = a;
        in_first = f;
        stats_clear = clr;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!acc) chk("send_timeout", 32'(n), 32'(0));
        in_valid = 1'b0;
        stats_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_sym_count", 32'(sym_count), 32'(0));
        chk("rst_sat_count", 32'(sat_count), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        idle(2);
        chk("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("init_out_valid", 32'(out_valid), 32'(0));
        chk("init_in_ready", 32'(in_ready), 32'(1));
        chk("init_out_symbol", 32'(out_symbol), 32'(0));
        chk("init_out_first", 32'(out_first), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Delta path
        send(8'd100, 1'b1, 1'b0);
        send(8'd110, 1'b0, 1'b0);
        send(8'd105, 1'b0, 1'b0);
        drain();

        // Clamping without drift
        send(8'd255, 1'b1, 1'b0);
        send(8'd255, 1'b0, 1'b0);
        send(8'd255, 1'b0, 1'b0);
        send(8'd0, 1'b1, 1'b0);
        send(8'd255, 1'b0, 1'b0);
        send(8'd0, 1'b0, 1'b0);
        drain();

        // Backpressure: six offered with the output stalled
        out_ready = 1'b0;
        fork
            begin
                send(8'd40, 1'b1, 1'b0);
                send(8'd200, 1'b0, 1'b0);
                send(8'd7, 1'b0, 1'b0);
                send(8'd90, 1'b0, 1'b0);
                send(8'd91, 1'b0, 1'b0);
                send(8'd255, 1'b0, 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Clear coinciding with a clamped accept, then saturate the narrow counter
        send(8'd255, 1'b1, 1'b1);
        idle(2);
        for (int i = 0; i < 20; i++) send(8'd255, 1'b1, 1'b0);
        drain();

        // Frame boundary
        send(8'd10, 1'b0, 1'b1);
        send(8'd20, 1'b0, 1'b0);
        send(8'd30, 1'b1, 1'b0);
        drain();

        // Reset mid-transfer, then restart
        out_ready = 1'b0;
        send(8'd60, 1'b0, 1'b0);
        send(8'd61, 1'b0, 1'b0);
        do_reset();
        out_ready = 1'b1;
        send(8'd50, 1'b1, 1'b0);
        drain();

        // Randomized stream with random backpressure, gaps, frames and clears
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 5))
                0: a = '0;
                1: a = '1;
                default: a = AW'($urandom_range(0, (1 << AW) - 1));
            endcase
            send(a, ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
